// File: rtl/hazard_pkg.sv
// Shared types and constants for the MIPS pipeline stall/flush controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_e;

    localparam int REG_ZERO     = 0;
    localparam int WAIT_MAX_DEF = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register the ID instruction reads.
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exRd,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUsesRt,
    output logic             loadUse
);

    logic rsHit;
    logic rtHit;

    assign rsHit   = (exRd == idRs);
    assign rtHit   = idUsesRt && (exRd == idRt);
    // $zero is never a real dependency.
    assign loadUse = exMemRead && (exRd != REG_W'(REG_ZERO)) && (rsHit || rtHit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int REG_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             id_jr,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events,
`endif
    output logic             busy
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    hazard_state_e state, nextState;
    logic [CNT_W-1:0] waitCnt, nextCnt;
    logic timeoutNext;
    logic loadUse;

    hazard_detect #(.REG_W(REG_W)) uDetect (
        .exMemRead (ex_mem_read),
        .exRd      (ex_rd),
        .idRs      (id_rs),
        .idRt      (id_rt),
        .idUsesRt  (id_uses_rt),
        .loadUse   (loadUse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            waitCnt     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= nextState;
            waitCnt     <= nextCnt;
            mem_timeout <= timeoutNext;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        busy         = 1'b0;
        nextState    = state;
        nextCnt      = waitCnt;
        timeoutNext  = 1'b0;
        // Reset forces the idle output set regardless of the registered state.
        if (!reset) begin
            unique case (state)
                RUN: begin
                    mem_req = mem_access;
                    if (mem_access && !mem_ready) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        nextState    = MEM_WAIT;
                        nextCnt      = CNT_W'(1);
                    end else if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (loadUse) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (id_jump || id_jr) begin
                        if_id_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    mem_req = 1'b1;
                    busy    = 1'b1;
                    // A withdrawn access completes just like a ready one.
                    if (mem_ready || !mem_access) begin
                        nextState = RUN;
                        nextCnt   = '0;
                    end else if (waitCnt == CNT_W'(WAIT_MAX)) begin
                        mem_wb_flush = 1'b1;
                        timeoutNext  = 1'b1;
                        nextState    = RUN;
                        nextCnt      = '0;
                    end else begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        ex_mem_write = 1'b0;
                        mem_wb_flush = 1'b1;
                        nextCnt      = waitCnt + CNT_W'(1);
                    end
                end
                default: nextState = RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if ((if_id_flush || id_ex_flush) && (flush_events != 32'hFFFF_FFFF))
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios plus random traffic.
module tb_pipeline_hazard_ctrl;

    localparam int WAIT_MAX = 4;
    localparam int REG_W    = 5;

    typedef struct packed {
        logic        memReq;
        logic        pcWrite;
        logic        ifIdWrite;
        logic        ifIdFlush;
        logic        idExWrite;
        logic        idExFlush;
        logic        exMemWrite;
        logic        memWbFlush;
        logic        memTimeout;
        logic        busy;
        logic [31:0] stalls;
        logic [31:0] flushes;
    } outs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic id_uses_rt = 0, id_jump = 0, id_jr = 0, ex_mem_read = 0;
    logic ex_branch_taken = 0, mem_access = 0, mem_ready = 0;
    logic mem_req, pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, mem_wb_flush, mem_timeout, busy;
    logic [31:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .REG_W(REG_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_jr(id_jr),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .mem_ready(mem_ready),
        .mem_req(mem_req), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .mem_wb_flush(mem_wb_flush),
        .mem_timeout(mem_timeout),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
        .busy(busy)
    );

`ifndef HAZARD_PERF_CNT_EN
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

    outs_t expQ[$];
    int checks = 0;
    int errors = 0;

    // Reference model: "waiting" plus how many cycles the access has been outstanding.
    bit          mWaiting = 0;
    int          mWaited  = 0;
    bit          mTimedOut = 0;
    logic [31:0] mStalls = 0, mFlushes = 0;

    task automatic step(input logic rst, input logic acc, input logic rdy,
                        input logic ld, input logic [REG_W-1:0] rd,
                        input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                        input logic usesRt, input logic br, input logic jmp, input logic jr);
        outs_t e;
        bit depends;
        bit stall;
        @(posedge clk);
        #1;
        reset = rst; mem_access = acc; mem_ready = rdy; ex_mem_read = ld;
        ex_rd = rd; id_rs = rs; id_rt = rt; id_uses_rt = usesRt;
        ex_branch_taken = br; id_jump = jmp; id_jr = jr;

        e = '0;
        e.pcWrite = 1; e.ifIdWrite = 1; e.idExWrite = 1; e.exMemWrite = 1;
        e.memTimeout = mTimedOut;
        e.stalls = mStalls;
        e.flushes = mFlushes;
        depends = ld && (rd != 0) && ((rd == rs) || (usesRt && (rd == rt)));
        stall = 0;
        mTimedOut = 0;

        if (rst) begin
            mWaiting = 0; mWaited = 0;
        end else if (mWaiting) begin
            e.memReq = 1; e.busy = 1;
            if (rdy || !acc) begin
                mWaiting = 0; mWaited = 0;
            end else if (mWaited >= WAIT_MAX) begin
                e.memWbFlush = 1;
                mTimedOut = 1;
                mWaiting = 0; mWaited = 0;
            end else begin
                stall = 1;
                mWaited++;
            end
        end else begin
            e.memReq = acc;
            if (acc && !rdy) begin
                stall = 1;
                mWaiting = 1; mWaited = 1;
            end else if (br) begin
                e.ifIdFlush = 1; e.idExFlush = 1;
            end else if (depends) begin
                e.pcWrite = 0; e.ifIdWrite = 0; e.idExFlush = 1;
            end else if (jmp || jr) begin
                e.ifIdFlush = 1;
            end
        end
        if (stall) begin
            e.pcWrite = 0; e.ifIdWrite = 0; e.idExWrite = 0; e.exMemWrite = 0;
            e.memWbFlush = 1;
        end

        if (rst) begin
            mStalls = 0; mFlushes = 0;
        end else begin
            if (!e.pcWrite && mStalls != 32'hFFFF_FFFF) mStalls++;
            if ((e.ifIdFlush || e.idExFlush) && mFlushes != 32'hFFFF_FFFF) mFlushes++;
        end
        expQ.push_back(e);
    endtask

    task automatic idle(input logic rst);
        step(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle, so each negedge retires one expectation.
    initial begin
        outs_t e, a;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                a = '0;
                a.memReq = mem_req; a.pcWrite = pc_write; a.ifIdWrite = if_id_write;
                a.ifIdFlush = if_id_flush; a.idExWrite = id_ex_write;
                a.idExFlush = id_ex_flush; a.exMemWrite = ex_mem_write;
                a.memWbFlush = mem_wb_flush; a.memTimeout = mem_timeout; a.busy = busy;
`ifdef HAZARD_PERF_CNT_EN
                a.stalls = stall_cycles; a.flushes = flush_events;
`else
                a.stalls = e.stalls; a.flushes = e.flushes;
`endif
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got req=%b pc=%b ifw=%b iff=%b idw=%b idf=%b exw=%b wbf=%b to=%b busy=%b st=%0d fl=%0d exp req=%b pc=%b ifw=%b iff=%b idw=%b idf=%b exw=%b wbf=%b to=%b busy=%b st=%0d fl=%0d",
                             $time, a.memReq, a.pcWrite, a.ifIdWrite, a.ifIdFlush, a.idExWrite,
                             a.idExFlush, a.exMemWrite, a.memWbFlush, a.memTimeout, a.busy,
                             a.stalls, a.flushes,
                             e.memReq, e.pcWrite, e.ifIdWrite, e.ifIdFlush, e.idExWrite,
                             e.idExFlush, e.exMemWrite, e.memWbFlush, e.memTimeout, e.busy,
                             e.stalls, e.flushes);
                end
            end
        end
    end

    initial begin
        int budget;
        idle(1); idle(1); idle(0);
        // Load-use on rs, then the same with $zero as destination.
        step(0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0, 0);
        idle(0);
        step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        // Load-use on rt, with and without rt actually being read.
        step(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1, 0, 0, 0);
        step(0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 0, 0, 0, 0);
        // Branch beats load-use; load-use beats jump; bare jump and jr.
        step(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
        // Single-cycle access, then a 3-cycle memory wait with hazards that must be ignored.
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 5'd4, 5'd4, 5'd0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        // Timeout: mem_ready never arrives.
        for (int i = 0; i < WAIT_MAX + 1; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0); idle(0);
        // Access withdrawn while waiting.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset mid-wait, including one armed to time out.
        for (int i = 0; i < WAIT_MAX; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        // Random traffic over a tiny register space so dependencies are common.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
        end
        budget = 20;
        while (expQ.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending exp 0 pending", expQ.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline. It watches the ID, EX and MEM stages and drives write-enables and flushes to the PC and to IF_ID, ID_EX, EX_MEM and MEM_WB. It resolves three hazard types:
- load-use data hazards;
- taken branches and jumps;
- multi-cycle data-memory accesses, using a req/ready handshake with a timeout.

Parameters:
WAIT_MAX, 16, maximum cycles spent in MEM_WAIT before a timeout abort (1..255)
REG_W, 5, register-specifier width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
id_rs  in  REG_W  rs field of the instruction in ID
id_rt  in  REG_W  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt
id_jump  in  1  J/JAL decoded in ID
id_jr  in  1  JR decoded in ID
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_W  destination register of the instruction in EX
ex_branch_taken  in  1  BEQ/BNE resolved taken in EX
mem_access  in  1  memReadOut|memWriteOut of EX_MEM (MEM-stage access)
mem_ready  in  1  data memory completes the access this cycle
mem_req  out  1  data-memory request strobe
pc_write  out  1  PC update enable
if_id_write  out  1  IF_ID load enable
if_id_flush  out  1  IF_ID clear to bubble
id_ex_write  out  1  ID_EX load enable
id_ex_flush  out  1  ID_EX clear to bubble
ex_mem_write  out  1  EX_MEM load enable
mem_wb_flush  out  1  MEM_WB clear to bubble
mem_timeout  out  1  one-cycle pulse when a memory wait is aborted
busy  out  1  FSM is in MEM_WAIT

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high. Sampled at posedge clk; state → RUN, wait_cnt → 0, mem_timeout → 0.
- Outputs during reset and in idle RUN with no hazards:
  - all write enables = 1;
  - all flushes = 0;
  - mem_req = 0;
  - busy = 0.
- Outputs are combinational from the registered state, wait_cnt and the current inputs. mem_timeout is registered.
- FSM states: RUN, MEM_WAIT.
- RUN, priority order (highest first):
  1. Memory stall: mem_access=1 & mem_ready=0 →
     - mem_req=1;
     - pc_write, if_id_write, id_ex_write, ex_mem_write = 0;
     - mem_wb_flush=1;
     - next state MEM_WAIT, wait_cnt ← 1.
     - mem_access=1 & mem_ready=1 → mem_req=1, no stall (single-cycle access).
  2. Branch taken: ex_branch_taken=1 → if_id_flush=1, id_ex_flush=1. This overrides a simultaneous load-use or jump, since those instructions are squashed.
  3. Load-use: ex_mem_read & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)) →
     - pc_write=0, if_id_write=0, id_ex_flush=1;
     - exactly one bubble, because the load advances to MEM next cycle.
     - This overrides a simultaneous id_jump/id_jr; the jump is re-evaluated the next cycle.
  4. Jump: id_jump | id_jr → if_id_flush=1.
- MEM_WAIT:
  - Outputs are held as in the RUN memory-stall case (mem_req=1, busy=1).
  - Branch, jump and load-use hazards are ignored; no flushes other than mem_wb_flush are asserted.
  - mem_ready=1:
    - release all enables this cycle (EX_MEM advances);
    - mem_wb_flush=0;
    - next state RUN, wait_cnt ← 0.
  - mem_ready=0 & wait_cnt==WAIT_MAX:
    - mem_timeout pulses the next cycle;
    - next state RUN, wait_cnt ← 0;
    - enables are released this cycle and the access is dropped.
  - Otherwise wait_cnt increments.
  - mem_access dropping to 0 in MEM_WAIT is treated as mem_ready: return to RUN.
- Reset mid-wait: abort immediately, no timeout pulse.
- wait_cnt width = $clog2(WAIT_MAX+1); it never wraps.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles counts every cycle with pc_write=0.
  - flush_events counts every cycle with if_id_flush|id_ex_flush.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - FSM state enum (RUN=1'b0, MEM_WAIT=1'b1);
  - REG_ZERO constant;
  - default WAIT_MAX.
- One natural sub-module, hazard_detect: purely combinational load-use comparator, instantiated once.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8 → pc_write=0, if_id_write=0, id_ex_flush=1 for exactly one cycle. Repeat with ex_rd=0 → no stall.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with a load-use match → if_id_flush=1, id_ex_flush=1, pc_write=1.
- Memory wait: mem_access=1, mem_ready low for 3 cycles then high → busy high for 3 cycles, enables low, mem_wb_flush high; enables restored in the mem_ready cycle.
- Timeout: WAIT_MAX=4, mem_ready held 0 → return to RUN after the wait_cnt==4 cycle; mem_timeout=1 for exactly 1 cycle.
- Reset mid-wait: assert reset during MEM_WAIT → next cycle busy=0, all enables=1, mem_timeout=0.
- HAZARD_PERF_CNT_EN: 3-cycle memory stall plus one load-use → stall_cycles=4, flush_events=1.
